// File: rtl/perf_sample_engine.sv
// Perf-counter sampler: periodic/external triggers read mhpmcounters over the shared CSR port and stream valid/ready frames.
// Optional timestamp beat (idx 7) is compiled in with PERF_SAMPLE_TIMESTAMP_EN.
module perf_sample_engine #(
  parameter int          NumCounters  = 6,
  parameter logic [11:0] CounterBase  = 12'hB03,
  parameter logic [11:0] CounterHBase = 12'hB83,
  parameter int          Xlen         = 64,
  parameter int          PeriodWidth  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   trigger_i,
  input  logic [63:0]            cycle_count_i,
  input  logic                   csr_req_i,
  input  logic [11:0]            csr_addr_i,
  input  logic                   csr_we_i,
  input  logic [Xlen-1:0]        csr_wdata_i,
  output logic [Xlen-1:0]        csr_rdata_o,
  output logic [11:0]            perf_addr_o,
  output logic                   perf_we_o,
  output logic [Xlen-1:0]        perf_wdata_o,
  input  logic [Xlen-1:0]        perf_rdata_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [63:0]            sample_data_o,
  output logic [2:0]             sample_idx_o,
  output logic                   sample_last_o,
  output logic                   busy_o,
  output logic [15:0]            overrun_cnt_o
);

  localparam logic [2:0] LastK = 3'(NumCounters - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TS,
    S_READ_LO,
    S_READ_HI,
    S_EMIT
  } state_t;

  state_t                 r_state;
  logic [PeriodWidth-1:0] r_timer;
  logic                   r_pending;
  logic [2:0]             r_k;
  logic [63:0]            r_data;
  logic                   r_valid;
  logic [2:0]             r_idx;
  logic                   r_last;
  logic [15:0]            r_overrun;

  logic        w_tmr_on;
  logic        w_ptrig;
  logic        w_trig;
  logic        w_busy;
  logic [63:0] w_rd64;
  logic [31:0] w_rd_lo32;

  assign w_tmr_on  = enable_i && (period_i != '0);
  assign w_ptrig   = w_tmr_on && (r_timer == PeriodWidth'(1));
  assign w_trig    = w_ptrig || trigger_i;
  assign w_busy    = (r_state != S_IDLE);
  assign w_rd64    = 64'(perf_rdata_i);
  assign w_rd_lo32 = perf_rdata_i[31:0];

`ifndef PERF_SAMPLE_TIMESTAMP_EN
  logic w_unused_cc;
  assign w_unused_cc = ^cycle_count_i;
`endif

  // A timer value of 0 (after reset) just reloads without firing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer <= '0;
    end else if (!w_tmr_on || r_timer <= PeriodWidth'(1)) begin
      r_timer <= period_i;
    end else begin
      r_timer <= r_timer - PeriodWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= '0;
    end else if (w_trig && (r_pending || w_busy) && (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_k       <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_last    <= 1'b0;
    end else begin
      if (w_busy && w_trig) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        // A trigger seen while idle starts the frame in the same cycle.
        S_IDLE: begin
          if (r_pending || w_trig) begin
            r_pending <= 1'b0;
            r_k       <= '0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
            r_state   <= S_TS;
            r_data    <= cycle_count_i;
            r_valid   <= 1'b1;
            r_idx     <= 3'd7;
            r_last    <= 1'b0;
`else
            r_state   <= S_READ_LO;
`endif
          end
        end
`ifdef PERF_SAMPLE_TIMESTAMP_EN
        S_TS: begin
          if (sample_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_READ_LO;
          end
        end
`endif
        S_READ_LO: begin
          if (!csr_req_i) begin
            r_data <= w_rd64;
            if (Xlen == 32) begin
              r_state <= S_READ_HI;
            end else begin
              r_state <= S_EMIT;
              r_valid <= 1'b1;
              r_idx   <= r_k;
              r_last  <= (r_k == LastK);
            end
          end
        end
        S_READ_HI: begin
          if (!csr_req_i) begin
            r_data[63:32] <= w_rd_lo32;
            r_state       <= S_EMIT;
            r_valid       <= 1'b1;
            r_idx         <= r_k;
            r_last        <= (r_k == LastK);
          end
        end
        S_EMIT: begin
          if (sample_ready_i) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state <= S_IDLE;
            end else begin
              r_k     <= r_k + 3'd1;
              r_state <= S_READ_LO;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CSR file always wins the port; the engine itself only ever reads.
  always_comb begin
    perf_addr_o  = 12'h000;
    perf_we_o    = 1'b0;
    perf_wdata_o = '0;
    csr_rdata_o  = '0;
    if (csr_req_i) begin
      perf_addr_o  = csr_addr_i;
      perf_we_o    = csr_we_i;
      perf_wdata_o = csr_wdata_i;
      csr_rdata_o  = perf_rdata_i;
    end else if (r_state == S_READ_LO) begin
      perf_addr_o = CounterBase + {9'b0, r_k};
    end else if (r_state == S_READ_HI) begin
      perf_addr_o = CounterHBase + {9'b0, r_k};
    end
  end

  assign sample_valid_o = r_valid;
  assign sample_data_o  = r_data;
  assign sample_idx_o   = r_idx;
  assign sample_last_o  = r_last;
  assign busy_o         = w_busy;
  assign overrun_cnt_o  = r_overrun;

endmodule

// File: tb/tb_perf_sample_engine.sv
// Bench for perf_sample_engine: 64-bit six-counter instance plus a 32-bit single-counter instance.
module tb_perf_sample_engine;

`ifdef PERF_SAMPLE_TIMESTAMP_EN
  localparam int TSX = 1;
`else
  localparam int TSX = 0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  i;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // main instance signals
  logic        enable, trigger, csr_req, csr_we, perf_we, svld, srdy, slast, busy;
  logic [31:0] period;
  logic [63:0] cc, csr_wdata, csr_rdata, perf_wdata, prdata, sdata;
  logic [11:0] csr_addr, paddr;
  logic [2:0]  sidx;
  logic [15:0] ovr;

  // 32-bit instance signals
  logic        trig2, perf_we2, svld2, slast2, busy2;
  logic [31:0] csr_rdata2, perf_wdata2, prdata2;
  logic [11:0] paddr2;
  logic [63:0] sdata2;
  logic [2:0]  sidx2;
  logic [15:0] ovr2;

  beat_t       q1[$];
  beat_t       q2[$];
  logic [11:0] alog[$];
  logic [11:0] alog2[$];
  int          last_cyc = 0;
  logic        we_bad = 1'b0;

  function automatic logic [63:0] perf_model(input logic [11:0] a);
    if (a >= 12'hB03 && a <= 12'hB08) return 64'(a - 12'hB02);
    if (a == 12'h300) return 64'hCAFE_0000_0000_0300;
    return 64'h0;
  endfunction

  assign prdata  = perf_model(paddr);
  assign prdata2 = (paddr2 == 12'hB03) ? 32'h1 : (paddr2 == 12'hB83) ? 32'h2 : 32'h0;

  perf_sample_engine u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .period_i(period),
    .trigger_i(trigger), .cycle_count_i(cc), .csr_req_i(csr_req),
    .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .perf_addr_o(paddr), .perf_we_o(perf_we),
    .perf_wdata_o(perf_wdata), .perf_rdata_i(prdata), .sample_valid_o(svld),
    .sample_ready_i(srdy), .sample_data_o(sdata), .sample_idx_o(sidx),
    .sample_last_o(slast), .busy_o(busy), .overrun_cnt_o(ovr)
  );

  perf_sample_engine #(.NumCounters(1), .Xlen(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(1'b0), .period_i(32'h0),
    .trigger_i(trig2), .cycle_count_i(cc), .csr_req_i(1'b0),
    .csr_addr_i(12'h000), .csr_we_i(1'b0), .csr_wdata_i(32'h0),
    .csr_rdata_o(csr_rdata2), .perf_addr_o(paddr2), .perf_we_o(perf_we2),
    .perf_wdata_o(perf_wdata2), .perf_rdata_i(prdata2), .sample_valid_o(svld2),
    .sample_ready_i(1'b1), .sample_data_o(sdata2), .sample_idx_o(sidx2),
    .sample_last_o(slast2), .busy_o(busy2), .overrun_cnt_o(ovr2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame1();
    if (TSX != 0) q1.push_back(beat_t'{d: 64'd100, i: 3'd7, l: 1'b0});
    for (int k = 0; k < 6; k++)
      q1.push_back(beat_t'{d: 64'(k + 1), i: 3'(k), l: (k == 5)});
  endtask

  task automatic pulse_trigger(output int tc);
    trigger = 1'b1;
    tc = cyc;
    tick();
    trigger = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) tick();
    chk({nm, "_drain"}, 64'(q1.size() + q2.size()), 64'd0);
  endtask

  task automatic chk_addrs(input string nm, input int base);
    chk({nm, "_nreads"}, 64'(alog.size()), 64'd6);
    for (int k = 0; k < 6 && k < alog.size(); k++)
      chk({nm, "_addr"}, 64'(alog[k]), 64'(base + k));
  endtask

  // Scoreboard monitors: pop and compare on every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (perf_we && !csr_req) we_bad <= 1'b1;
      if (perf_we2) we_bad <= 1'b1;
      if (!csr_req && paddr != 12'h000) alog.push_back(paddr);
      if (paddr2 != 12'h000) alog2.push_back(paddr2);
      if (svld && srdy) begin
        if (q1.size() == 0) begin
          chk("unexpected_beat", {61'b0, sidx}, 64'hFFFF);
        end else begin
          beat_t e;
          e = q1.pop_front();
          chk("beat_data", sdata, e.d);
          chk("beat_idx", 64'(sidx), 64'(e.i));
          chk("beat_last", 64'(slast), 64'(e.l));
        end
        if (slast) last_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && svld2) begin
      if (q2.size() == 0) begin
        chk("unexpected_beat32", {61'b0, sidx2}, 64'hFFFF);
      end else begin
        beat_t e;
        e = q2.pop_front();
        chk("beat32_data", sdata2, e.d);
        chk("beat32_idx", 64'(sidx2), 64'(e.i));
        chk("beat32_last", 64'(slast2), 64'(e.l));
      end
    end
  end

  initial begin
    int tc;
    int n;
    rst_n = 1'b0; enable = 1'b0; period = 32'd0; trigger = 1'b0; cc = 64'd100;
    csr_req = 1'b0; csr_addr = 12'h0; csr_we = 1'b0; csr_wdata = 64'h0;
    srdy = 1'b1; trig2 = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(svld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(ovr), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_csr_rdata", csr_rdata, 64'd0);
    chk("rst_data_idx_last", {sdata[59:0], sidx, slast}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame, ready tied high.
    alog.delete();
    push_frame1();
    pulse_trigger(tc);
    chk("busy_after_trigger", 64'(busy), 64'd1);
    drain("frame1", 60);
    chk("frame1_latency", 64'(last_cyc - tc), 64'(12 + TSX));
    chk_addrs("frame1", 'hB03);

    // CSR contention during READ_LO.
    alog.delete();
    push_frame1();
    pulse_trigger(tc);
    if (TSX != 0) tick();
    csr_req = 1'b1; csr_addr = 12'h300; csr_we = 1'b1; csr_wdata = 64'h55;
    #1;
    chk("csr_addr_pass", 64'(paddr), 64'h300);
    chk("csr_rdata_pass", csr_rdata, 64'hCAFE_0000_0000_0300);
    chk("csr_we_pass", {63'b0, perf_we}, 64'd1);
    chk("csr_wdata_pass", perf_wdata, 64'h55);
    repeat (3) tick();
    csr_req = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 64'h0;
    drain("csr", 60);
    chk("csr_latency", 64'(last_cyc - tc), 64'(15 + TSX));
    chk_addrs("csr", 'hB03);

    // Backpressure on beat 2 holds the beat and issues no extra reads.
    alog.delete();
    push_frame1();
    pulse_trigger(tc);
    n = 0;
    while (!(svld && sidx == 3'd2) && n < 20) begin
      tick();
      n++;
    end
    chk("beat2_seen", 64'(n < 20), 64'd1);
    srdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_hold", {sdata[59:0], sidx, svld}, {60'd3, 3'd2, 1'b1});
      chk("stall_last", 64'(slast), 64'd0);
    end
    srdy = 1'b1;
    drain("stall", 60);
    chk_addrs("stall", 'hB03);

    // Periodic triggers with the sink blocked: one frame runs, one pends, three overruns.
    period = 32'd10;
    srdy = 1'b0;
    tick();
    enable = 1'b1;
    repeat (45) tick();
    chk("period_overrun", 64'(ovr), 64'd3);
    chk("period_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    push_frame1();
    push_frame1();
    srdy = 1'b1;
    drain("period", 100);
    chk("period_idle", 64'(busy), 64'd0);
    chk("period_overrun_hold", 64'(ovr), 64'd3);

    // 32-bit port: low then high word of one counter.
    alog2.delete();
    if (TSX != 0) q2.push_back(beat_t'{d: 64'd100, i: 3'd7, l: 1'b0});
    q2.push_back(beat_t'{d: 64'h0000_0002_0000_0001, i: 3'd0, l: 1'b1});
    trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    drain("x32", 30);
    chk("x32_nreads", 64'(alog2.size()), 64'd2);
    if (alog2.size() == 2) begin
      chk("x32_addr_lo", 64'(alog2[0]), 64'hB03);
      chk("x32_addr_hi", 64'(alog2[1]), 64'hB83);
    end

    // Reset mid-frame clears everything at once.
    push_frame1();
    pulse_trigger(tc);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(svld), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_overrun", 64'(ovr), 64'd0);
    q1.delete();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_quiet", 64'(busy), 64'd0);

    chk("we_never_from_engine", 64'(we_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
